mac_dec: RTL and testbench



---
 rtl/mac_dec.sv | 185 ++++++++++++++++++
 tb/tb_mac_dec.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_dec.sv
// Inbound frame decoder: round-robin arbiter over four PHY receive FIFOs that
// copies each frame into the body FIFO and emits one tagged MAC header per frame.
module mac_dec (
    input  logic        clk,
    input  logic        arst,
    input  logic [7:0]  i0_fifo_dout,
    input  logic        i0_fifo_empty,
    input  logic        i0_fifo_afull,
    input  logic        i0_fifo_half,
    input  logic        i0_fifo_frame_exist,
    output logic        i0_fifo_rden,
    input  logic        i0_fifo_del,
    input  logic [7:0]  i1_fifo_dout,
    input  logic        i1_fifo_empty,
    input  logic        i1_fifo_afull,
    input  logic        i1_fifo_half,
    input  logic        i1_fifo_frame_exist,
    output logic        i1_fifo_rden,
    input  logic        i1_fifo_del,
    input  logic [7:0]  i2_fifo_dout,
    input  logic        i2_fifo_empty,
    input  logic        i2_fifo_afull,
    input  logic        i2_fifo_half,
    input  logic        i2_fifo_frame_exist,
    output logic        i2_fifo_rden,
    input  logic        i2_fifo_del,
    input  logic [7:0]  i3_fifo_dout,
    input  logic        i3_fifo_empty,
    input  logic        i3_fifo_afull,
    input  logic        i3_fifo_half,
    input  logic        i3_fifo_frame_exist,
    output logic        i3_fifo_rden,
    input  logic        i3_fifo_del,
    output logic [97:0] h_fifo_din,
    input  logic        h_fifo_full,
    output logic        h_fifo_wren,
    output logic [7:0]  b_fifo_din,
    input  logic        b_fifo_afull,
    output logic        b_fifo_wren,
    output logic        b_fifo_del
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_XFER = 1'b1;

    logic [3:0][7:0] dout_s;
    logic [3:0]      empty_s;
    logic [3:0]      del_s;
    logic [3:0]      afull_s;
    logic [3:0]      half_s;
    logic [3:0]      fe_s;
    logic [3:0]      afull_meta_r;
    logic [3:0]      afull_sync_r;
    logic [3:0]      half_meta_r;
    logic [3:0]      half_sync_r;
    logic [3:0]      elig_s;
    logic [0:0]      state_r;
    logic [1:0]      last_r;
    logic [1:0]      sel_r;
    logic [3:0]      cnt_r;
    logic [47:0]     dst_r;
    logic [47:0]     src_r;
    logic [47:0]     dst_nx_s;
    logic [47:0]     src_nx_s;
    logic [7:0]      sel_dout_s;
    logic            sel_empty_s;
    logic            sel_del_s;
    logic            rd_s;
    logic            go_s;
    logic            hdr_s;

    // First eligible port strictly after the last-served one, wrapping 0..3.
    function automatic logic [1:0] rr_pick(input logic [1:0] last, input logic [3:0] elig);
        logic [1:0] cand;
        logic [1:0] pick;
        logic       found;
        logic       hit;
        pick  = last;
        found = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            cand  = last + 2'(i);
            hit   = !found && elig[cand];
            pick  = hit ? cand : pick;
            found = found | hit;
        end
        return pick;
    endfunction

    assign dout_s  = {i3_fifo_dout, i2_fifo_dout, i1_fifo_dout, i0_fifo_dout};
    assign empty_s = {i3_fifo_empty, i2_fifo_empty, i1_fifo_empty, i0_fifo_empty};
    assign del_s   = {i3_fifo_del, i2_fifo_del, i1_fifo_del, i0_fifo_del};
    assign afull_s = {i3_fifo_afull, i2_fifo_afull, i1_fifo_afull, i0_fifo_afull};
    assign half_s  = {i3_fifo_half, i2_fifo_half, i1_fifo_half, i0_fifo_half};
    assign fe_s    = {i3_fifo_frame_exist, i2_fifo_frame_exist, i1_fifo_frame_exist, i0_fifo_frame_exist};

    assign elig_s      = fe_s | afull_sync_r | half_sync_r;
    assign sel_dout_s  = dout_s[sel_r];
    assign sel_empty_s = empty_s[sel_r];
    assign sel_del_s   = del_s[sel_r];
    assign rd_s        = (state_r == ST_XFER) && !sel_empty_s && !b_fifo_afull;
    assign go_s        = (state_r == ST_IDLE) && !h_fifo_full && !b_fifo_afull && (|elig_s);
    // A runt still gets its header on the final byte so header and body frame counts match.
    assign hdr_s       = rd_s && ((cnt_r == 4'd11) || (sel_del_s && (cnt_r < 4'd11)));

    assign {i3_fifo_rden, i2_fifo_rden, i1_fifo_rden, i0_fifo_rden} =
        rd_s ? (4'b0001 << sel_r) : 4'b0000;

    // Address bytes as they will look once the current byte is captured.
    always_comb begin
        dst_nx_s = dst_r;
        src_nx_s = src_r;
        for (int i = 0; i < 6; i++) begin
            dst_nx_s[47-8*i -: 8] = (cnt_r == 4'(i))     ? sel_dout_s : dst_r[47-8*i -: 8];
            src_nx_s[47-8*i -: 8] = (cnt_r == 4'(i + 6)) ? sel_dout_s : src_r[47-8*i -: 8];
        end
    end

    // Two-flop synchronisers for the foreign-domain fill levels.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            afull_meta_r <= 4'b0000;
            afull_sync_r <= 4'b0000;
            half_meta_r  <= 4'b0000;
            half_sync_r  <= 4'b0000;
        end else begin
            afull_meta_r <= afull_s;
            afull_sync_r <= afull_meta_r;
            half_meta_r  <= half_s;
            half_sync_r  <= half_meta_r;
        end
    end

    // Arbitration FSM, address capture and registered FIFO write side.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_r     <= ST_IDLE;
            last_r      <= 2'd3;
            sel_r       <= 2'd0;
            cnt_r       <= 4'd0;
            dst_r       <= 48'h0;
            src_r       <= 48'h0;
            b_fifo_din  <= 8'h00;
            b_fifo_del  <= 1'b0;
            b_fifo_wren <= 1'b0;
            h_fifo_din  <= 98'h0;
            h_fifo_wren <= 1'b0;
        end else begin
            b_fifo_wren <= rd_s;
            b_fifo_del  <= rd_s & sel_del_s;
            h_fifo_wren <= hdr_s;
            if (rd_s) begin
                b_fifo_din <= sel_dout_s;
            end
            if (hdr_s) begin
                h_fifo_din <= {sel_r, dst_nx_s, src_nx_s};
            end
            case (state_r)
                ST_IDLE: begin
                    if (go_s) begin
                        sel_r   <= rr_pick(last_r, elig_s);
                        cnt_r   <= 4'd0;
                        dst_r   <= 48'h0;
                        src_r   <= 48'h0;
                        state_r <= ST_XFER;
                    end
                end
                ST_XFER: begin
                    if (rd_s) begin
                        dst_r <= dst_nx_s;
                        src_r <= src_nx_s;
                        if (cnt_r < 4'd12) begin
                            cnt_r <= cnt_r + 4'd1;
                        end
                        if (sel_del_s) begin
                            state_r <= ST_IDLE;
                            last_r  <= sel_r;
                        end
                    end
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mac_dec.sv
// Directed self-checking bench for mac_dec: models four show-ahead PHY FIFOs
// and logs body/header writes and pops with cycle stamps.
module tb_mac_dec;

    logic        clk = 1'b0;
    logic        arst = 1'b1;
    logic        h_fifo_full = 1'b0;
    logic        b_fifo_afull = 1'b0;
    logic [97:0] h_fifo_din;
    logic        h_fifo_wren;
    logic [7:0]  b_fifo_din;
    logic        b_fifo_wren;
    logic        b_fifo_del;
    logic        i0_fifo_rden, i1_fifo_rden, i2_fifo_rden, i3_fifo_rden;
    logic [3:0]  rden_v;

    logic [8:0]  mem [4][256];
    logic [7:0]  wp [4] = '{default: 8'd0};
    logic [7:0]  rp [4] = '{default: 8'd0};
    int          dpush [4] = '{default: 0};
    int          dpop [4] = '{default: 0};
    logic [3:0]  fe_en = 4'b0000;
    logic [3:0]  hold = 4'b0000;
    logic [3:0]  afull_in = 4'b0000;

    typedef struct { int cyc; logic [7:0] b; logic d; } body_t;
    typedef struct { int cyc; logic [97:0] w; } hdr_t;
    typedef struct { int cyc; int port; } rd_t;
    body_t body_q[$];
    hdr_t  hdr_q[$];
    rd_t   rd_q[$];
    int    cyc = 0;
    int    multi_rd = 0;
    int    n_cmp = 0;
    int    n_bad = 0;

    always #5 clk = ~clk;

    assign rden_v = {i3_fifo_rden, i2_fifo_rden, i1_fifo_rden, i0_fifo_rden};

    mac_dec dut (
        .clk(clk), .arst(arst),
        .i0_fifo_dout(mem[0][rp[0]][7:0]), .i0_fifo_empty((rp[0] == wp[0]) | hold[0]),
        .i0_fifo_afull(afull_in[0]), .i0_fifo_half(1'b0),
        .i0_fifo_frame_exist(fe_en[0] & (dpush[0] != dpop[0])),
        .i0_fifo_rden(i0_fifo_rden), .i0_fifo_del(mem[0][rp[0]][8]),
        .i1_fifo_dout(mem[1][rp[1]][7:0]), .i1_fifo_empty((rp[1] == wp[1]) | hold[1]),
        .i1_fifo_afull(afull_in[1]), .i1_fifo_half(1'b0),
        .i1_fifo_frame_exist(fe_en[1] & (dpush[1] != dpop[1])),
        .i1_fifo_rden(i1_fifo_rden), .i1_fifo_del(mem[1][rp[1]][8]),
        .i2_fifo_dout(mem[2][rp[2]][7:0]), .i2_fifo_empty((rp[2] == wp[2]) | hold[2]),
        .i2_fifo_afull(afull_in[2]), .i2_fifo_half(1'b0),
        .i2_fifo_frame_exist(fe_en[2] & (dpush[2] != dpop[2])),
        .i2_fifo_rden(i2_fifo_rden), .i2_fifo_del(mem[2][rp[2]][8]),
        .i3_fifo_dout(mem[3][rp[3]][7:0]), .i3_fifo_empty((rp[3] == wp[3]) | hold[3]),
        .i3_fifo_afull(afull_in[3]), .i3_fifo_half(1'b0),
        .i3_fifo_frame_exist(fe_en[3] & (dpush[3] != dpop[3])),
        .i3_fifo_rden(i3_fifo_rden), .i3_fifo_del(mem[3][rp[3]][8]),
        .h_fifo_din(h_fifo_din), .h_fifo_full(h_fifo_full), .h_fifo_wren(h_fifo_wren),
        .b_fifo_din(b_fifo_din), .b_fifo_afull(b_fifo_afull),
        .b_fifo_wren(b_fifo_wren), .b_fifo_del(b_fifo_del)
    );

    // PHY FIFO pop side.
    always @(posedge clk) begin
        for (int n = 0; n < 4; n++) begin
            if (rden_v[n]) begin
                rp[n] <= rp[n] + 8'd1;
                if (mem[n][rp[n]][8]) dpop[n] <= dpop[n] + 1;
            end
        end
    end

    // Cycle-stamped log of everything the DUT writes or pops.
    always @(posedge clk) begin
        if (b_fifo_wren) body_q.push_back('{cyc, b_fifo_din, b_fifo_del});
        if (h_fifo_wren) hdr_q.push_back('{cyc, h_fifo_din});
        for (int n = 0; n < 4; n++) if (rden_v[n]) rd_q.push_back('{cyc, n});
        if ($countones(rden_v) > 1) multi_rd <= multi_rd + 1;
        cyc <= cyc + 1;
    end

    task automatic push(input int n, input logic [7:0] b, input logic d);
        mem[n][wp[n]] = {d, b};
        wp[n] = wp[n] + 8'd1;
        if (d) dpush[n] = dpush[n] + 1;
    endtask

    task automatic flush(input int n);
        wp[n] = rp[n];
        dpush[n] = dpop[n];
    endtask

    task automatic clear_logs();
        body_q.delete();
        hdr_q.delete();
        rd_q.delete();
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({rden_v, b_fifo_wren, h_fifo_wren, b_fifo_del} !== 7'b0) begin
            n_bad++; $display("FAIL reset_strobes: got %b want 0", {rden_v, b_fifo_wren, h_fifo_wren, b_fifo_del});
        end
        n_cmp++;
        if ({h_fifo_din, b_fifo_din} !== 106'h0) begin
            n_bad++; $display("FAIL reset_data: got %h/%h want 0", h_fifo_din, b_fifo_din);
        end
    endtask

    task automatic test_blocked_release();
        logic [97:0] exp_h;
        h_fifo_full = 1'b1;
        b_fifo_afull = 1'b1;
        afull_in[1] = 1'b1;
        push(0, 8'h02, 1'b0); push(2, 8'h02, 1'b0); push(3, 8'h02, 1'b0);
        for (int i = 0; i < 13; i++) push(1, 8'h02 + 8'(i), 1'b0);
        push(1, 8'hFF, 1'b1);
        @(negedge clk);
        arst = 1'b0;
        repeat (10) @(negedge clk);
        n_cmp++;
        if (rd_q.size() != 0 || body_q.size() != 0 || hdr_q.size() != 0) begin
            n_bad++; $display("FAIL blocked: got rd=%0d body=%0d hdr=%0d want 0", rd_q.size(), body_q.size(), hdr_q.size());
        end
        h_fifo_full = 1'b0;
        b_fifo_afull = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (rden_v !== 4'b0010) begin
            n_bad++; $display("FAIL release_rden: got %b want 0010", rden_v);
        end
        flush(0); flush(2); flush(3);
        push(3, 8'h30, 1'b0); push(3, 8'h31, 1'b1);
        fe_en[3] = 1'b1;
        afull_in[1] = 1'b0;
        for (int k = 0; k < 100 && body_q.size() < 14; k++) @(negedge clk);
        n_cmp++;
        if (body_q.size() < 14 || rd_q.size() < 14) begin
            n_bad++; $display("FAIL frame1_len: got %0d want 14", body_q.size());
        end else begin
            for (int i = 0; i < 14; i++) begin
                n_cmp++;
                if (body_q[i].b !== ((i == 13) ? 8'hFF : 8'h02 + 8'(i)) || body_q[i].d !== (i == 13)
                    || rd_q[i].port != 1 || rd_q[i].cyc != rd_q[0].cyc + i) begin
                    n_bad++; $display("FAIL frame1_byte%0d: got %h del=%b port=%0d", i, body_q[i].b, body_q[i].d, rd_q[i].port);
                end
            end
            n_cmp++;
            if (body_q[0].cyc != rd_q[0].cyc + 1) begin
                n_bad++; $display("FAIL body_latency: got %0d want %0d", body_q[0].cyc, rd_q[0].cyc + 1);
            end
            exp_h = {2'd1, 48'h020304050607, 48'h08090A0B0C0D};
            n_cmp++;
            if (hdr_q.size() < 1 || hdr_q[0].w !== exp_h || hdr_q[0].cyc != rd_q[11].cyc + 1) begin
                n_bad++; $display("FAIL hdr1: got %h want %h", (hdr_q.size() > 0) ? hdr_q[0].w : 98'h0, exp_h);
            end
        end
    endtask

    task automatic test_end_of_frame();
        for (int k = 0; k < 50 && body_q.size() < 16; k++) @(negedge clk);
        repeat (3) @(negedge clk);
        n_cmp++;
        if (body_q.size() != 16 || rd_q.size() != 16) begin
            n_bad++; $display("FAIL eof_len: got %0d want 16", body_q.size());
        end else begin
            n_cmp++;
            if (rd_q[14].port != 3 || rd_q[14].cyc != rd_q[13].cyc + 2) begin
                n_bad++; $display("FAIL eof_gap: got port %0d cyc %0d want port 3 cyc %0d", rd_q[14].port, rd_q[14].cyc, rd_q[13].cyc + 2);
            end
            n_cmp++;
            if (body_q[15].b !== 8'h31 || body_q[15].d !== 1'b1 || body_q[14].d !== 1'b0) begin
                n_bad++; $display("FAIL eof_next: got %h del=%b want 31 del=1", body_q[15].b, body_q[15].d);
            end
        end
        n_cmp++;
        if (hdr_q.size() != 2 || hdr_q[1].w !== {2'd3, 48'h303100000000, 48'h0}) begin
            n_bad++; $display("FAIL hdr_port3: got %0d headers, last %h", hdr_q.size(), (hdr_q.size() > 1) ? hdr_q[1].w : 98'h0);
        end
        fe_en[3] = 1'b0;
    endtask

    task automatic test_round_robin();
        logic [7:0] exp_b [4];
        int         exp_p [4];
        exp_b = '{8'h10, 8'h20, 8'h11, 8'h21};
        exp_p = '{0, 2, 0, 2};
        clear_logs();
        push(0, 8'h10, 1'b1); push(0, 8'h11, 1'b1);
        push(2, 8'h20, 1'b1); push(2, 8'h21, 1'b1);
        fe_en = 4'b0101;
        for (int k = 0; k < 60 && body_q.size() < 4; k++) @(negedge clk);
        repeat (3) @(negedge clk);
        n_cmp++;
        if (body_q.size() != 4 || hdr_q.size() != 4 || rd_q.size() != 4) begin
            n_bad++; $display("FAIL rr_counts: got body=%0d hdr=%0d want 4", body_q.size(), hdr_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_cmp++;
                if (rd_q[i].port != exp_p[i] || body_q[i].b !== exp_b[i] || body_q[i].d !== 1'b1
                    || hdr_q[i].w !== {2'(exp_p[i]), exp_b[i], 40'h0, 48'h0}) begin
                    n_bad++; $display("FAIL rr_%0d: got port %0d byte %h hdr %h want port %0d", i, rd_q[i].port, body_q[i].b, hdr_q[i].w, exp_p[i]);
                end
            end
        end
        fe_en = 4'b0000;
    endtask

    task automatic test_back_pressure();
        int nr;
        int nb;
        clear_logs();
        for (int i = 0; i < 20; i++) push(0, 8'h40 + 8'(i), i == 19);
        fe_en[0] = 1'b1;
        for (int k = 0; k < 50 && rd_q.size() < 4; k++) @(negedge clk);
        b_fifo_afull = 1'b1;
        @(posedge clk);
        #1;
        nr = rd_q.size();
        nb = body_q.size();
        repeat (4) @(negedge clk);
        n_cmp++;
        if (rd_q.size() != nr || body_q.size() != nb) begin
            n_bad++; $display("FAIL afull_stall: got rd +%0d wr +%0d want 0", rd_q.size() - nr, body_q.size() - nb);
        end
        b_fifo_afull = 1'b0;
        hold[0] = 1'b1;
        nr = rd_q.size();
        nb = body_q.size();
        repeat (3) @(negedge clk);
        n_cmp++;
        if (rd_q.size() != nr || body_q.size() != nb) begin
            n_bad++; $display("FAIL empty_stall: got rd +%0d wr +%0d want 0", rd_q.size() - nr, body_q.size() - nb);
        end
        hold[0] = 1'b0;
        for (int k = 0; k < 60 && body_q.size() < 20; k++) @(negedge clk);
        repeat (3) @(negedge clk);
        n_cmp++;
        if (body_q.size() != 20) begin
            n_bad++; $display("FAIL bp_len: got %0d want 20", body_q.size());
        end else begin
            for (int i = 0; i < 20; i++) begin
                n_cmp++;
                if (body_q[i].b !== 8'h40 + 8'(i) || body_q[i].d !== (i == 19)) begin
                    n_bad++; $display("FAIL bp_byte%0d: got %h del=%b want %h", i, body_q[i].b, body_q[i].d, 8'h40 + 8'(i));
                end
            end
        end
        n_cmp++;
        if (hdr_q.size() != 1 || hdr_q[0].w !== {2'd0, 48'h404142434445, 48'h464748494A4B}) begin
            n_bad++; $display("FAIL bp_hdr: got %0d headers, first %h", hdr_q.size(), (hdr_q.size() > 0) ? hdr_q[0].w : 98'h0);
        end
        fe_en[0] = 1'b0;
    endtask

    task automatic test_runt();
        logic [7:0] exp_b [4];
        exp_b = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        clear_logs();
        for (int i = 0; i < 4; i++) push(1, exp_b[i], i == 3);
        fe_en[1] = 1'b1;
        for (int k = 0; k < 40 && body_q.size() < 4; k++) @(negedge clk);
        repeat (3) @(negedge clk);
        n_cmp++;
        if (body_q.size() != 4) begin
            n_bad++; $display("FAIL runt_len: got %0d want 4", body_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_cmp++;
                if (body_q[i].b !== exp_b[i] || body_q[i].d !== (i == 3)) begin
                    n_bad++; $display("FAIL runt_byte%0d: got %h del=%b want %h", i, body_q[i].b, body_q[i].d, exp_b[i]);
                end
            end
            n_cmp++;
            if (hdr_q.size() != 1 || hdr_q[0].w !== {2'd1, 48'hAABBCCDD0000, 48'h0} || hdr_q[0].cyc != body_q[3].cyc) begin
                n_bad++; $display("FAIL runt_hdr: got %0d headers, first %h", hdr_q.size(), (hdr_q.size() > 0) ? hdr_q[0].w : 98'h0);
            end
        end
        fe_en[1] = 1'b0;
    endtask

    task automatic test_reset_mid_frame();
        clear_logs();
        for (int i = 0; i < 10; i++) push(2, 8'h60 + 8'(i), i == 9);
        fe_en[2] = 1'b1;
        for (int k = 0; k < 40 && rd_q.size() < 5; k++) @(negedge clk);
        arst = 1'b1;
        #1;
        n_cmp++;
        if ({rden_v, b_fifo_wren, h_fifo_wren, b_fifo_del} !== 7'b0 || {h_fifo_din, b_fifo_din} !== 106'h0) begin
            n_bad++; $display("FAIL midreset_outputs: got rden=%b bw=%b hw=%b bd=%h", rden_v, b_fifo_wren, h_fifo_wren, b_fifo_din);
        end
        @(negedge clk);
        flush(2);
        fe_en[2] = 1'b0;
        arst = 1'b0;
        @(negedge clk);
        clear_logs();
        push(3, 8'h70, 1'b1);
        push(0, 8'h71, 1'b1);
        fe_en = 4'b1001;
        for (int k = 0; k < 40 && body_q.size() < 2; k++) @(negedge clk);
        n_cmp++;
        if (rd_q.size() < 2 || rd_q[0].port != 0 || rd_q[1].port != 3) begin
            n_bad++; $display("FAIL midreset_priority: got %0d pops, first port %0d want 0", rd_q.size(), (rd_q.size() > 0) ? rd_q[0].port : -1);
        end
        fe_en = 4'b0000;
    endtask

    task automatic test_onehot();
        n_cmp++;
        if (multi_rd != 0) begin
            n_bad++; $display("FAIL rden_onehot: got %0d multi-rden cycles want 0", multi_rd);
        end
    endtask

    initial begin
        test_reset();
        test_blocked_release();
        test_end_of_frame();
        test_round_robin();
        test_back_pressure();
        test_runt();
        test_reset_mid_frame();
        test_onehot();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
